// File: rtl/int_ctrl.sv
// int_ctrl: multi-source interrupt controller with pending/mask registers,
// fixed-priority selection (source 0 highest) and a req/ack/eoi handshake
// towards the CPU control unit.
module int_ctrl #(
    parameter int unsigned N_SRC    = 8,
    parameter int unsigned DATA_W   = 16,
    parameter bit          EDGE_DET = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [N_SRC-1:0]  Irq,
    input  logic              Write,
    input  logic [1:0]        Sel,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              IntReq,
    input  logic              IntAck,
    output logic [3:0]        IntId,
    input  logic              IntEoi,
    output logic              InService
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state;
    logic [N_SRC-1:0]   mask;
    logic [N_SRC-1:0]   pend;
    logic [N_SRC-1:0]   irq_d;
    logic [N_SRC-1:0]   evt;
    logic [N_SRC-1:0]   sw_set;
    logic [N_SRC-1:0]   sw_clr;
    logic [N_SRC-1:0]   ack_clr;
    logic [N_SRC-1:0]   id_sel;
    logic [N_SRC-1:0]   active;
    logic               id_active;
    logic               ack_fire;
    logic [3:0]         enc;
    logic               enc_found;

    // Bits of WData above N_SRC carry no meaning for this block.
    generate
        if (DATA_W > N_SRC) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^WData[DATA_W-1:N_SRC];
        end
    endgenerate

    assign evt      = EDGE_DET ? (Irq & ~irq_d) : Irq;
    assign sw_set   = (Write && Sel == 2'd2) ? WData[N_SRC-1:0] : '0;
    assign sw_clr   = (Write && Sel == 2'd1) ? WData[N_SRC-1:0] : '0;
    assign ack_fire = (state == REQ) && IntAck;
    assign active   = pend & mask;

    // One-hot decode of the latched IntId, used for ack-clear and withdrawal.
    always_comb begin
        id_sel = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            id_sel[i] = (IntId == 4'(i));
        end
    end

    assign ack_clr   = ack_fire ? id_sel : '0;
    assign id_active = |(active & id_sel);

    // Fixed-priority encoder: lowest set index of the active set wins.
    always_comb begin
        enc       = '0;
        enc_found = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (!enc_found && active[i]) begin
                enc       = 4'(i);
                enc_found = 1'b1;
            end
        end
    end

    // Mask, pending and edge-history registers; set wins over clear.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            mask  <= '0;
            pend  <= '0;
            irq_d <= '0;
        end else begin
            irq_d <= Irq;
            if (Write && Sel == 2'd0) begin
                mask <= WData[N_SRC-1:0];
            end
            pend <= (pend & ~(sw_clr | ack_clr)) | evt | sw_set;
        end
    end

    // Handshake FSM with registered IntReq/IntId/InService.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            IntReq    <= 1'b0;
            IntId     <= '0;
            InService <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|active) begin
                        IntId  <= enc;
                        IntReq <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    // Acknowledge beats a same-cycle withdrawal.
                    if (IntAck) begin
                        IntReq    <= 1'b0;
                        InService <= 1'b1;
                        state     <= SERVICE;
                    end else if (!id_active) begin
                        IntReq <= 1'b0;
                        state  <= IDLE;
                    end
                end
                SERVICE: begin
                    if (IntEoi) begin
                        InService <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    IntReq    <= 1'b0;
                    InService <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Combinational register read port.
    always_comb begin
        RData = '0;
        case (Sel)
            2'd0:    RData[N_SRC-1:0] = mask;
            2'd1:    RData[N_SRC-1:0] = pend;
            2'd2:    RData[N_SRC-1:0] = pend;
            default: RData[5:0]       = {InService, IntReq, IntId};
        endcase
    end

endmodule
